// File: rtl/rope_pkg.sv
// Shared types and width constants for the tug-of-war rope game controller.
// Holds the game state encoding, the winner encoding and the default widths
// used by the top and the per-player pull accumulator.
package rope_pkg;

   // Default widths; the top exposes these as overridable parameters.
   localparam int ROPE_LOC_W  = 10;
   localparam int ROPE_PEND_W = 3;

   // Signed net pull needs one extra bit over a pending counter.
   localparam int ROPE_NET_EXTRA = 1;
   // Position arithmetic: sign bit plus one headroom bit above LOC_W.
   localparam int ROPE_SUM_EXTRA = 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_PLAY      = 2'd2,
      ST_WIN       = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      WNR_NONE = 2'b00,
      WNR_A    = 2'b01,
      WNR_B    = 2'b10
   } winner_e;

endpackage

// File: rtl/rope_pull_accum.sv
// Per-player saturating pending-pull counter for the current video frame.
// Latency: count visible the cycle after a pull; clear and load share one edge.
// A pull arriving on the clearing edge loads 1, so it lands in the next frame.
module rope_pull_accum #(
   parameter int PEND_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [PEND_W-1:0] cnt_o
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic [PEND_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins over hold, but a coincident pull reloads as one.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = inc_i ? CNT_ONE : '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rope_game_ctrl.sv
// Tug-of-war sequencer: countdown, per-frame rope movement from pended pulls, winner detect.
// Latency: pull reaches o_rope_loc within one frame plus one cycle; win state one cycle later.
// No backpressure: pull/start/tick pulses are sampled every cycle and never stalled.
module rope_game_ctrl
   import rope_pkg::*;
#(
   parameter int LOC_W        = ROPE_LOC_W,
   parameter int CENTER       = 320,
   parameter int STEP         = 4,
   parameter int WIN_DIST     = 64,
   parameter int PEND_W       = ROPE_PEND_W,
   parameter int COUNT_FRAMES = 180,
   parameter int WIN_FRAMES   = 120
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_frame_tick,
   input  logic             i_pull_a,
   input  logic             i_pull_b,
   output logic [LOC_W-1:0] o_rope_loc,
   output logic [1:0]       o_state,
   output logic [1:0]       o_winner,
   output logic             o_song_start,
   output logic [7:0]       o_total_a,
   output logic [7:0]       o_total_b
);

   localparam int SUM_W  = LOC_W + ROPE_SUM_EXTRA;
   localparam int NET_W  = PEND_W + ROPE_NET_EXTRA;
   localparam int FCNT_W = 8;

   localparam logic [LOC_W-1:0]  LOC_CTR = LOC_W'(CENTER);
   localparam logic [LOC_W-1:0]  LOC_MAX = LOC_W'(2 * CENTER);
   localparam logic [LOC_W-1:0]  LOC_LO  = LOC_W'(CENTER - WIN_DIST);
   localparam logic [LOC_W-1:0]  LOC_HI  = LOC_W'(CENTER + WIN_DIST);
   localparam logic [FCNT_W-1:0] CD_LAST = FCNT_W'(COUNT_FRAMES - 1);
   localparam logic [FCNT_W-1:0] WN_LAST = FCNT_W'(WIN_FRAMES - 1);
   localparam logic [7:0]        TOT_MAX = 8'hFF;

   state_e            state_q, state_d;
   winner_e           winner_q, winner_d;
   logic [LOC_W-1:0]  loc_q, loc_d;
   logic [7:0]        tot_a_q, tot_a_d;
   logic [7:0]        tot_b_q, tot_b_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              song_q, song_d;

   logic              pend_clr;
   logic              acc_a, acc_b;
   logic              win_a, win_b;
   logic [PEND_W-1:0] pend_a, pend_b;

   logic signed [NET_W-1:0] net_s;
   logic signed [SUM_W-1:0] loc_s, step_s, max_s, new_s;
   logic [LOC_W-1:0]        loc_next;

   rope_pull_accum #(.PEND_W(PEND_W)) u_accum_a (
      .clk   (clk),
      .rst   (rst),
      .clr_i (pend_clr),
      .inc_i (acc_a),
      .cnt_o (pend_a)
   );

   rope_pull_accum #(.PEND_W(PEND_W)) u_accum_b (
      .clk   (clk),
      .rst   (rst),
      .clr_i (pend_clr),
      .inc_i (acc_b),
      .cnt_o (pend_b)
   );

   // Win detection looks at the registered position, one cycle after an update.
   assign win_a = (loc_q <= LOC_LO);
   assign win_b = (loc_q >= LOC_HI);

   // Next rope position from this frame's net pulls, clamped to the visible track.
   always_comb begin
      net_s  = $signed({1'b0, pend_b}) - $signed({1'b0, pend_a});
      loc_s  = $signed({2'b00, loc_q});
      step_s = $signed(SUM_W'(STEP));
      max_s  = $signed({2'b00, LOC_MAX});
      new_s  = loc_s + (SUM_W'(net_s) * step_s);
      if (new_s < 0) begin
         loc_next = '0;
      end else if (new_s > max_s) begin
         loc_next = LOC_MAX;
      end else begin
         loc_next = new_s[LOC_W-1:0];
      end
   end

   // Game sequencing: state transitions, frame counting, position and totals.
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      loc_d    = loc_q;
      tot_a_d  = tot_a_q;
      tot_b_d  = tot_b_q;
      fcnt_d   = fcnt_q;
      song_d   = 1'b0;
      pend_clr = 1'b0;
      acc_a    = 1'b0;
      acc_b    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d  = ST_COUNTDOWN;
               loc_d    = LOC_CTR;
               winner_d = WNR_NONE;
               tot_a_d  = '0;
               tot_b_d  = '0;
               fcnt_d   = '0;
               pend_clr = 1'b1;
               song_d   = 1'b1;
            end
         end
         ST_COUNTDOWN: begin
            if (i_frame_tick) begin
               if (fcnt_q == CD_LAST) begin
                  state_d = ST_PLAY;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (win_a || win_b) begin
               // Game is decided; this cycle's pulls and ticks no longer matter.
               state_d  = ST_WIN;
               winner_d = win_a ? WNR_A : WNR_B;
               fcnt_d   = '0;
            end else begin
               acc_a = i_pull_a;
               acc_b = i_pull_b;
               if (i_frame_tick) begin
                  loc_d    = loc_next;
                  pend_clr = 1'b1;
               end
            end
         end
         ST_WIN: begin
            if (i_frame_tick) begin
               if (fcnt_q == WN_LAST) begin
                  state_d = ST_IDLE;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (acc_a && (tot_a_q != TOT_MAX)) begin
         tot_a_d = tot_a_q + 1'b1;
      end
      if (acc_b && (tot_b_q != TOT_MAX)) begin
         tot_b_d = tot_b_q + 1'b1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         winner_q <= WNR_NONE;
         loc_q    <= LOC_CTR;
         tot_a_q  <= '0;
         tot_b_q  <= '0;
         fcnt_q   <= '0;
         song_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         loc_q    <= loc_d;
         tot_a_q  <= tot_a_d;
         tot_b_q  <= tot_b_d;
         fcnt_q   <= fcnt_d;
         song_q   <= song_d;
      end
   end

   assign o_rope_loc   = loc_q;
   assign o_state      = state_q;
   assign o_winner     = winner_q;
   assign o_song_start = song_q;
   assign o_total_a    = tot_a_q;
   assign o_total_b    = tot_b_q;

endmodule

// File: tb/tb_rope_game_ctrl.sv
// Directed bench for rope_game_ctrl: vector table for the main game flow,
// hand-written sequences for winning, post-win behaviour and mid-game reset.
module tb_rope_game_ctrl;

   logic       clk;
   logic       rst;
   logic       i_start;
   logic       i_frame_tick;
   logic       i_pull_a;
   logic       i_pull_b;
   logic [9:0] o_rope_loc;
   logic [1:0] o_state;
   logic [1:0] o_winner;
   logic       o_song_start;
   logic [7:0] o_total_a;
   logic [7:0] o_total_b;

   int n_checks;
   int n_fail;

   typedef struct {
      logic       rst;
      logic       start;
      logic       tick;
      logic       pa;
      logic       pb;
      logic [1:0] st;
      logic [9:0] loc;
      logic [1:0] win;
      logic       song;
      logic [7:0] ta;
      logic [7:0] tb;
   } vec_t;

   vec_t vecs[$];

   rope_game_ctrl #(
      .LOC_W        (10),
      .CENTER       (320),
      .STEP         (4),
      .WIN_DIST     (64),
      .PEND_W       (3),
      .COUNT_FRAMES (3),
      .WIN_FRAMES   (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_frame_tick (i_frame_tick),
      .i_pull_a     (i_pull_a),
      .i_pull_b     (i_pull_b),
      .o_rope_loc   (o_rope_loc),
      .o_state      (o_state),
      .o_winner     (o_winner),
      .o_song_start (o_song_start),
      .o_total_a    (o_total_a),
      .o_total_b    (o_total_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, and leave outputs settled for sampling.
   task automatic cyc(input logic r, input logic s, input logic t,
                      input logic a, input logic b);
      rst          = r;
      i_start      = s;
      i_frame_tick = t;
      i_pull_a     = a;
      i_pull_b     = b;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      i_start      = 1'b0;
      i_frame_tick = 1'b0;
      i_pull_a     = 1'b0;
      i_pull_b     = 1'b0;
   endtask

   task automatic add(input logic r, input logic s, input logic t,
                      input logic a, input logic b,
                      input int st, input int loc, input int win,
                      input int song, input int ta, input int tb);
      vec_t v;
      v.rst = r; v.start = s; v.tick = t; v.pa = a; v.pb = b;
      v.st = st[1:0]; v.loc = loc[9:0]; v.win = win[1:0];
      v.song = song[0]; v.ta = ta[7:0]; v.tb = tb[7:0];
      vecs.push_back(v);
   endtask

   task automatic check_all(input string tag, input int st, input int loc,
                            input int win, input int song, input int ta, input int tb);
      check({tag, ".state"},  int'(o_state),      st);
      check({tag, ".loc"},    int'(o_rope_loc),   loc);
      check({tag, ".winner"}, int'(o_winner),     win);
      check({tag, ".song"},   int'(o_song_start), song);
      check({tag, ".tot_a"},  int'(o_total_a),    ta);
      check({tag, ".tot_b"},  int'(o_total_b),    tb);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      i_start      = 1'b0;
      i_frame_tick = 1'b0;
      i_pull_a     = 1'b0;
      i_pull_b     = 1'b0;

      // ---------------- vector table: {rst,start,tick,pa,pb} -> outputs after edge
      add(1,0,0,0,0, 0,320,0,0, 0,0);
      add(1,0,0,0,0, 0,320,0,0, 0,0);
      add(0,0,0,0,0, 0,320,0,0, 0,0);
      add(0,1,0,0,0, 1,320,0,1, 0,0);   // start: song pulse
      add(0,0,0,0,0, 1,320,0,0, 0,0);   // pulse lasts one cycle
      add(0,0,0,1,1, 1,320,0,0, 0,0);   // pulls ignored in countdown
      add(0,1,0,0,0, 1,320,0,0, 0,0);   // start ignored outside idle
      add(0,0,1,0,0, 1,320,0,0, 0,0);   // tick 1
      add(0,0,1,0,1, 1,320,0,0, 0,0);   // tick 2 with ignored pull
      add(0,0,1,0,0, 2,320,0,0, 0,0);   // tick 3 -> PLAY
      for (int i = 1; i <= 5; i++) add(0,0,0,0,1, 2,320,0,0, 0,i);
      add(0,0,1,0,0, 2,340,0,0, 0,5);   // +5*4
      for (int i = 1; i <= 3; i++) add(0,0,0,1,1, 2,340,0,0, i,5+i);
      add(0,0,1,0,0, 2,340,0,0, 3,8);   // net zero
      add(0,0,1,0,1, 2,340,0,0, 3,9);   // pull coincident with tick: deferred
      add(0,0,1,0,0, 2,344,0,0, 3,9);   // deferred pull applied
      for (int i = 1; i <= 6; i++) add(0,0,0,1,0, 2,344,0,0, 3+i,9);
      add(0,0,1,0,0, 2,320,0,0, 9,9);   // back to centre
      for (int i = 1; i <= 10; i++) add(0,0,0,1,0, 2,320,0,0, 9+i,9);
      add(0,0,1,0,0, 2,292,0,0, 19,9);  // pending saturated at 7: -28

      foreach (vecs[k]) begin
         cyc(vecs[k].rst, vecs[k].start, vecs[k].tick, vecs[k].pa, vecs[k].pb);
         check_all($sformatf("vec%0d", k), int'(vecs[k].st), int'(vecs[k].loc),
                   int'(vecs[k].win), int'(vecs[k].song),
                   int'(vecs[k].ta), int'(vecs[k].tb));
      end

      // ---------------- A wins: 292 -> 264 -> 256
      for (int i = 0; i < 7; i++) cyc(0,0,0,1,0);
      cyc(0,0,1,0,0);
      check_all("win.f1", 2, 264, 0, 0, 26, 9);
      cyc(0,0,0,1,0);
      cyc(0,0,0,1,0);
      cyc(0,0,1,0,0);
      check_all("win.f2", 2, 256, 0, 0, 28, 9);
      cyc(0,0,0,0,0);
      check_all("win.enter", 3, 256, 1, 0, 28, 9);
      cyc(0,0,0,1,1);
      check_all("win.pull_ign", 3, 256, 1, 0, 28, 9);
      cyc(0,1,0,0,0);
      check_all("win.start_ign", 3, 256, 1, 0, 28, 9);
      cyc(0,0,1,0,0);
      check_all("win.tick1", 3, 256, 1, 0, 28, 9);
      cyc(0,0,1,0,0);
      check_all("win.to_idle", 0, 256, 1, 0, 28, 9);
      cyc(0,0,1,1,1);
      check_all("idle.hold", 0, 256, 1, 0, 28, 9);

      // ---------------- new game, then reset mid-PLAY at loc 300
      cyc(0,1,0,0,0);
      check_all("g2.start", 1, 320, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0,0,1,0,0);
      check_all("g2.play", 2, 320, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0,0,0,1,0);
      cyc(0,0,1,0,0);
      check_all("g2.loc300", 2, 300, 0, 0, 5, 0);
      cyc(0,0,0,1,1);
      cyc(1,0,1,1,1);
      check_all("g2.reset", 0, 320, 0, 0, 0, 0);
      cyc(0,0,0,0,0);
      check_all("g2.after_rst", 0, 320, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
